// File: rtl/aes_pkg.sv
// Shared configuration for the AES ciphertext serializer: block/word geometry,
// FIFO depth, and the serializer state encoding.
package aes_pkg;

    localparam int DATA_W          = 128;
    localparam int WORD_W          = 32;
    localparam int FIFO_DEPTH      = 4;
    localparam int WORDS_PER_BLOCK = DATA_W / WORD_W;
    localparam int IDX_W           = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int LVL_W           = $clog2(FIFO_DEPTH) + 1;

    // Blocks must split into whole words; depth must be a power of two >= 2
    function automatic bit cfg_ok();
        return ((DATA_W % WORD_W) == 0) && (FIFO_DEPTH >= 2) &&
               ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);
    endfunction

    localparam bit CFG_OK = cfg_ok();

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } ser_state_e;

endpackage

// File: rtl/aes_ct_if.sv
// Cipher-side block input and consumer-side word stream of the serializer.
interface aes_ct_if;
    import aes_pkg::*;

    logic              valid_in;
    logic [DATA_W-1:0] cipher_text;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;

    modport slave (
        input  valid_in, cipher_text, word_ready,
        output word_out, word_valid, word_last, fifo_level, overflow
    );

    modport master (
        output valid_in, cipher_text, word_ready,
        input  word_out, word_valid, word_last, fifo_level, overflow
    );

endinterface

// File: rtl/aes_block_fifo.sv
// Synchronous block FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter.
module aes_block_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // A push while full only happens alongside a pop, so overwriting the head slot is safe
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign head  = mem[rptr[AW-1:0]];
    assign level = wptr - rptr;
    assign full  = (level == DEPTH_L);
    assign empty = (wptr == rptr);

endmodule

// File: rtl/aes_ct_serializer.sv
// Buffers 128-bit cipher blocks and streams them MSW-first as 32-bit words.
//   state    | meaning
//   ST_EMPTY | no block stored, word_valid low
//   ST_SEND  | head block presented, word widx on word_out
module aes_ct_serializer
    import aes_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    aes_ct_if.slave   bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    if (!CFG_OK) begin : g_cfg_err
        $error("aes_pkg: DATA_W must be a multiple of WORD_W and FIFO_DEPTH a power of 2 >= 2");
    end

    ser_state_e        state;
    ser_state_e        state_nxt;
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  widx_nxt;
    logic              word_hs;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [LVL_W-1:0]  level;
    logic              ovf;
    logic [WORD_W-1:0] word_sel;

    aes_block_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.cipher_text),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_nxt = state;
        widx_nxt  = widx;
        pop       = 1'b0;
        word_hs   = (state == ST_SEND) && bus.word_ready;
        if (word_hs) begin
            if (widx == LAST_IDX) begin
                widx_nxt = '0;
                pop      = 1'b1;
            end else begin
                widx_nxt = widx + 1'b1;
            end
        end
        // The final-word pop frees a slot in the same cycle, so a full FIFO can still accept
        push = bus.valid_in && (!full || pop);
        if (state == ST_EMPTY) begin
            if (push) state_nxt = ST_SEND;
        end else begin
            if (pop && !push && (level == LVL_W'(1))) state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
            widx  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            widx  <= widx_nxt;
            if (bus.valid_in && !push) ovf <= 1'b1;
        end
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            if (widx == IDX_W'(i)) word_sel = head[(WORDS_PER_BLOCK-1-i)*WORD_W +: WORD_W];
        end
    end

    assign bus.word_valid = (state == ST_SEND);
    assign bus.word_out   = (state == ST_SEND) ? word_sel : '0;
    assign bus.word_last  = (state == ST_SEND) && (widx == LAST_IDX);
    assign bus.fifo_level = level;
    assign bus.overflow   = ovf;

    logic unused_ok;
    assign unused_ok = empty;

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed bench for aes_ct_serializer: single block, back-pressure, bursts,
// reset mid-stream and full-FIFO simultaneous pop/push.
module tb_aes_ct_serializer;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_ct_if bus ();

    aes_ct_serializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests  = 0;
    int failed = 0;
    logic [DATA_W-1:0] blocks [5];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [WORD_W-1:0] wd(input int k, input int w);
        logic [DATA_W-1:0] b;
        b = blocks[k];
        return b[DATA_W-1-w*WORD_W -: WORD_W];
    endfunction

    task automatic expect_word(input string tag, input int k, input int w);
        chk({tag, "_valid"}, 128'(bus.word_valid), 128'(1'b1));
        chk({tag, "_word"},  128'(bus.word_out),   128'(wd(k, w)));
        chk({tag, "_last"},  128'(bus.word_last),  128'(w == 3));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, 128'(bus.word_valid), 128'(1'b0));
        chk({tag, "_word"},  128'(bus.word_out),   128'(0));
        chk({tag, "_last"},  128'(bus.word_last),  128'(1'b0));
        chk({tag, "_level"}, 128'(bus.fifo_level), 128'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.valid_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        blocks[0] = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        blocks[1] = 128'h10111213_14151617_18191a1b_1c1d1e1f;
        blocks[2] = 128'h20212223_24252627_28292a2b_2c2d2e2f;
        blocks[3] = 128'h30313233_34353637_38393a3b_3c3d3e3f;
        blocks[4] = 128'h40414243_44454647_48494a4b_4c4d4e4f;
        reset = 1'b1;
        bus.valid_in = 1'b0;
        bus.cipher_text = '0;
        bus.word_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset values
        expect_idle("rst");
        chk("rst_ovf", 128'(bus.overflow), 128'(1'b0));

        // Single FIPS-197 block at full speed
        bus.word_ready = 1'b1;
        bus.valid_in = 1'b1;
        bus.cipher_text = blocks[0];
        tick();
        bus.valid_in = 1'b0;
        chk("single_lvl1", 128'(bus.fifo_level), 128'(1));
        chk("single_w0_word", 128'(bus.word_out), 128'h69c4e0d8);
        expect_word("single_w0", 0, 0);
        tick(); chk("single_w1_word", 128'(bus.word_out), 128'h6a7b0430); expect_word("single_w1", 0, 1);
        tick(); chk("single_w2_word", 128'(bus.word_out), 128'hd8cdb780); expect_word("single_w2", 0, 2);
        tick(); chk("single_w3_word", 128'(bus.word_out), 128'h70b4c55a); expect_word("single_w3", 0, 3);
        tick(); expect_idle("single_done");

        // Back-pressure: word 0 holds while stalled
        bus.word_ready = 1'b0;
        bus.valid_in = 1'b1;
        bus.cipher_text = blocks[0];
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_word("bp_hold", 0, 0);
            if (i < 5) tick();
        end
        bus.word_ready = 1'b1;
        tick(); expect_word("bp_w1", 0, 1);
        tick(); expect_word("bp_w2", 0, 2);
        tick(); expect_word("bp_w3", 0, 3);
        tick(); expect_idle("bp_done");

        // Burst of 5 blocks at full speed: final pop frees the slot for block 4
        bus.word_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.valid_in = (c < 5);
            bus.cipher_text = blocks[c % 5];
            tick();
            expect_word("burst_fast", c / 4, c % 4);
            chk("burst_fast_lvl", 128'(bus.fifo_level), 128'(((c + 1 < 5) ? c + 1 : 5) - c / 4));
        end
        bus.valid_in = 1'b0;
        tick();
        expect_idle("burst_fast_done");
        chk("burst_fast_ovf", 128'(bus.overflow), 128'(1'b0));

        // Burst of 5 with stalled consumer: block 4 dropped
        bus.word_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.valid_in = 1'b1;
            bus.cipher_text = blocks[k];
            tick();
        end
        bus.valid_in = 1'b0;
        chk("stall_ovf", 128'(bus.overflow), 128'(1'b1));
        chk("stall_lvl", 128'(bus.fifo_level), 128'(4));
        expect_word("stall_head", 0, 0);
        bus.word_ready = 1'b1;
        for (int c = 1; c < 16; c++) begin
            tick();
            expect_word("stall_drain", c / 4, c % 4);
        end
        tick();
        expect_idle("stall_done");
        chk("stall_ovf_sticky", 128'(bus.overflow), 128'(1'b1));

        // Reset mid-block with two blocks stored; coincident valid_in ignored
        bus.word_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.valid_in = 1'b1;
            bus.cipher_text = blocks[k];
            tick();
        end
        bus.valid_in = 1'b0;
        bus.word_ready = 1'b1;
        tick();
        tick();
        expect_word("mid_pre", 0, 2);
        chk("mid_pre_lvl", 128'(bus.fifo_level), 128'(2));
        reset = 1'b1;
        bus.word_ready = 1'b0;
        bus.valid_in = 1'b1;
        bus.cipher_text = blocks[3];
        tick();
        reset = 1'b0;
        bus.valid_in = 1'b0;
        expect_idle("mid_rst");
        chk("mid_rst_ovf", 128'(bus.overflow), 128'(1'b0));
        tick();
        expect_idle("mid_rst_prio");
        bus.word_ready = 1'b1;
        bus.valid_in = 1'b1;
        bus.cipher_text = blocks[2];
        tick();
        bus.valid_in = 1'b0;
        expect_word("mid_new_w0", 2, 0);
        chk("mid_new_lvl", 128'(bus.fifo_level), 128'(1));
        tick(); expect_word("mid_new_w1", 2, 1);
        tick(); expect_word("mid_new_w2", 2, 2);
        tick(); expect_word("mid_new_w3", 2, 3);
        tick(); expect_idle("mid_new_done");

        // Simultaneous final pop and write while full
        do_reset();
        bus.word_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.valid_in = 1'b1;
            bus.cipher_text = blocks[k];
            tick();
        end
        bus.valid_in = 1'b0;
        chk("full_lvl", 128'(bus.fifo_level), 128'(4));
        bus.word_ready = 1'b1;
        tick();
        tick();
        tick();
        expect_word("full_last", 0, 3);
        bus.valid_in = 1'b1;
        bus.cipher_text = blocks[4];
        tick();
        bus.valid_in = 1'b0;
        chk("full_swap_lvl", 128'(bus.fifo_level), 128'(4));
        chk("full_swap_ovf", 128'(bus.overflow), 128'(1'b0));
        expect_word("full_swap", 1, 0);
        for (int c = 1; c < 16; c++) begin
            tick();
            expect_word("full_drain", 1 + c / 4, c % 4);
        end
        tick();
        expect_idle("full_done");
        chk("full_done_ovf", 128'(bus.overflow), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
